// File: rtl/frame_write_ctrl_pkg.sv
// Shared display constants, packer state encoding and raster address helper.
// Used by the frame writer, its raster counter and the bus interfaces.
package display_pkg;

    localparam int H_PIX   = 100;
    localparam int V_LINES = 100;
    localparam int PIX_W   = 24;
    localparam int CW      = 10;
    localparam int AW      = $clog2(H_PIX * V_LINES);

    typedef enum logic [1:0] {
        PACK0,
        PACK1,
        PACK2,
        WAIT_WR
    } pack_state_t;

    // Widen before multiplying so legal coordinates never truncate.
    function automatic logic [AW-1:0] addr_of(
        input logic [CW-1:0] x,
        input logic [CW-1:0] y
    );
        return AW'(y) * AW'(H_PIX) + AW'(x);
    endfunction

endpackage

// File: rtl/frame_write_ctrl_if.sv
// Byte-stream handshake and single-port frame memory bus.
// Master drives the request side; slave answers it.
interface byte_stream_if;
    import display_pkg::*;

    logic       byte_valid;
    logic [7:0] byte_in;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_in,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_in,
        output byte_ready
    );
endinterface

interface frame_mem_if;
    import display_pkg::*;

    logic             mem_en;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [PIX_W-1:0] mem_wdata;
    logic [PIX_W-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/frame_write_ctrl_raster_cnt.sv
// Raster position of the next pixel write, with clear, advance and
// a registered end-of-frame pulse.
module pixel_raster_cnt
    import display_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_done
);

    logic x_last;
    logic y_last;

    assign x_last = (x == CW'(H_PIX - 1));
    assign y_last = (y == CW'(V_LINES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (clr) begin
                x <= '0;
                y <= '0;
            end else if (adv) begin
                if (x_last) begin
                    x          <= '0;
                    y          <= y_last ? '0 : y + CW'(1);
                    frame_done <= y_last;
                end else begin
                    x <= x + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/frame_write_ctrl.sv
// Packs bytes into 24-bit pixels and writes them in raster order,
// sharing the frame memory port with scan-out reads (reads win).
module frame_write_ctrl
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof,
    byte_stream_if.slave     bs,
    input  logic             rd_req,
    input  logic [CW-1:0]    rd_x,
    input  logic [CW-1:0]    rd_y,
    output logic             rd_valid,
    output logic [PIX_W-1:0] rd_data,
    frame_mem_if.master      mem,
    output logic [CW-1:0]    wr_x,
    output logic [CW-1:0]    wr_y,
    output logic             frame_done
);

    pack_state_t      state;
    logic [PIX_W-1:0] pix;
    logic             accept;
    logic             wr_grant;
    logic             wr_do;
    logic             rd_ok;
    logic             rd_oor_q;

    assign bs.byte_ready = (state != WAIT_WR);
    assign accept        = bs.byte_valid && bs.byte_ready;
    assign wr_grant      = (state == WAIT_WR) && !rd_req;
    assign wr_do         = wr_grant && !sof;

    assign rd_ok = rd_req
                && (rd_x < CW'(H_PIX))
                && (rd_y < CW'(V_LINES));

    always_comb begin
        mem.mem_en    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        unique case (1'b1)
            rd_ok: begin
                mem.mem_en   = 1'b1;
                mem.mem_addr = addr_of(rd_x, rd_y);
            end
            wr_do: begin
                mem.mem_en    = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = addr_of(wr_x, wr_y);
                mem.mem_wdata = pix;
            end
            default: ;
        endcase
    end

    // sof drops any partial pixel; a byte taken with it starts pixel (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PACK0;
            pix   <= '0;
        end else if (sof) begin
            state <= accept ? PACK1 : PACK0;
            pix   <= accept ? PIX_W'(bs.byte_in) : '0;
        end else begin
            unique case (state)
                PACK0: if (accept) begin
                    pix[7:0] <= bs.byte_in;
                    state    <= PACK1;
                end
                PACK1: if (accept) begin
                    pix[15:8] <= bs.byte_in;
                    state     <= PACK2;
                end
                PACK2: if (accept) begin
                    pix[23:16] <= bs.byte_in;
                    state      <= WAIT_WR;
                end
                WAIT_WR: if (!rd_req) begin
                    state <= PACK0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_oor_q <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            rd_oor_q <= rd_req && !rd_ok;
        end
    end

    // Out-of-range reads never touched memory, so return zero.
    assign rd_data = (rd_valid && !rd_oor_q) ? mem.mem_rdata : '0;

    pixel_raster_cnt u_raster (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (sof),
        .adv        (wr_do),
        .x          (wr_x),
        .y          (wr_y),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed bench for frame_write_ctrl with a behavioural frame memory.
// Unwritten memory words read back as 0x5A0000 | address.
module tb_frame_write_ctrl;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        sof    = 1'b0;
    logic        rd_req = 1'b0;
    logic [9:0]  rd_x   = '0;
    logic [9:0]  rd_y   = '0;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic [9:0]  wr_x;
    logic [9:0]  wr_y;
    logic        frame_done;

    byte_stream_if bs();
    frame_mem_if   mi();

    frame_write_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sof        (sof),
        .bs         (bs),
        .rd_req     (rd_req),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .mem        (mi),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [23:0] mem_arr [10000];
    bit          wrn     [10000];
    logic [23:0] mrd     = '0;
    logic [13:0] last_wa = '0;
    int          wcnt    = 0;
    int          rcnt    = 0;
    int          fdcnt   = 0;
    int          checks  = 0;
    int          errors  = 0;

    assign mi.mem_rdata = mrd;

    always @(posedge clk) begin
        if (mi.mem_en && mi.mem_addr < 14'd10000) begin
            if (mi.mem_we) begin
                mem_arr[mi.mem_addr] <= mi.mem_wdata;
                wrn[mi.mem_addr]     <= 1'b1;
                last_wa              <= mi.mem_addr;
                wcnt                 <= wcnt + 1;
            end else begin
                mrd  <= wrn[mi.mem_addr] ? mem_arr[mi.mem_addr]
                                         : (24'h5A0000 | 24'(mi.mem_addr));
                rcnt <= rcnt + 1;
            end
        end
        if (frame_done) fdcnt <= fdcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        int n = 0;
        bs.byte_valid = 1'b1;
        bs.byte_in    = b;
        while (!bs.byte_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("byte_timeout", 32'(bs.byte_ready), 1);
        tick();
        bs.byte_valid = 1'b0;
    endtask

    task automatic send_px(input logic [23:0] px);
        put_byte(px[7:0]);
        put_byte(px[15:8]);
        put_byte(px[23:16]);
    endtask

    initial begin
        int w0;
        int r0;
        bs.byte_valid = 1'b0;
        bs.byte_in    = '0;

        // reset values
        repeat (2) tick();
        chk("rst_ready", 32'(bs.byte_ready), 1);
        chk("rst_wr_x", 32'(wr_x), 0);
        chk("rst_wr_y", 32'(wr_y), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_mem_en", 32'(mi.mem_en), 0);
        chk("rst_mem_addr", 32'(mi.mem_addr), 0);
        chk("rst_mem_wdata", 32'(mi.mem_wdata), 0);
        rst_n = 1'b1;
        tick();

        // first pixel
        send_px(24'h332211);
        #1;
        chk("t1_ready_low", 32'(bs.byte_ready), 0);
        chk("t1_mem_en", 32'(mi.mem_en), 1);
        chk("t1_mem_we", 32'(mi.mem_we), 1);
        chk("t1_mem_addr", 32'(mi.mem_addr), 0);
        chk("t1_mem_wdata", 32'(mi.mem_wdata), 32'h332211);
        tick();
        chk("t1_ready_back", 32'(bs.byte_ready), 1);
        chk("t1_wr_x", 32'(wr_x), 1);
        chk("t1_mem_idle", 32'(mi.mem_en), 0);
        chk("t1_wcnt", 32'(wcnt), 1);

        // reads stall a pending write
        send_px(24'h665544);
        w0 = wcnt;
        r0 = rcnt;
        rd_req = 1'b1; rd_x = 10'd7; rd_y = 10'd5;
        #1;
        chk("t2_r0_en", 32'(mi.mem_en), 1);
        chk("t2_r0_we", 32'(mi.mem_we), 0);
        chk("t2_r0_addr", 32'(mi.mem_addr), 507);
        chk("t2_r0_ready", 32'(bs.byte_ready), 0);
        tick();
        rd_x = 10'd8;
        #1;
        chk("t2_r1_valid", 32'(rd_valid), 1);
        chk("t2_r1_data", 32'(rd_data), 32'h5A01FB);
        chk("t2_r1_we", 32'(mi.mem_we), 0);
        chk("t2_r1_addr", 32'(mi.mem_addr), 508);
        chk("t2_r1_ready", 32'(bs.byte_ready), 0);
        tick();
        rd_x = 10'd9;
        #1;
        chk("t2_r2_data", 32'(rd_data), 32'h5A01FC);
        chk("t2_r2_ready", 32'(bs.byte_ready), 0);
        tick();
        rd_req = 1'b0;
        #1;
        chk("t2_r3_data", 32'(rd_data), 32'h5A01FD);
        chk("t2_r3_valid", 32'(rd_valid), 1);
        chk("t2_wr_we", 32'(mi.mem_we), 1);
        chk("t2_wr_addr", 32'(mi.mem_addr), 1);
        chk("t2_wr_wdata", 32'(mi.mem_wdata), 32'h665544);
        chk("t2_no_writes", 32'(wcnt - w0), 0);
        chk("t2_reads", 32'(rcnt - r0), 3);
        tick();
        chk("t2_valid_drop", 32'(rd_valid), 0);
        chk("t2_ready_back", 32'(bs.byte_ready), 1);
        chk("t2_wr_x", 32'(wr_x), 2);
        chk("t2_one_write", 32'(wcnt - w0), 1);

        // read back pixel 0
        rd_req = 1'b1; rd_x = 10'd0; rd_y = 10'd0;
        tick();
        rd_req = 1'b0;
        #1;
        chk("rb_data", 32'(rd_data), 32'h332211);
        tick();

        // full frame
        sof = 1'b1;
        tick();
        sof = 1'b0;
        chk("sof_wr_x", 32'(wr_x), 0);
        for (int p = 0; p < 10000; p++) send_px({8'hC3, 16'(p)});
        #1;
        chk("fr_last_addr", 32'(mi.mem_addr), 9999);
        chk("fr_last_we", 32'(mi.mem_we), 1);
        chk("fr_last_wdata", 32'(mi.mem_wdata), 32'hC3270F);
        tick();
        chk("fr_done_hi", 32'(frame_done), 1);
        chk("fr_wr_x", 32'(wr_x), 0);
        chk("fr_wr_y", 32'(wr_y), 0);
        chk("fr_model_addr", 32'(last_wa), 9999);
        tick();
        chk("fr_done_lo", 32'(frame_done), 0);
        chk("fr_done_cnt", 32'(fdcnt), 1);
        send_px(24'h030201);
        #1;
        chk("fr_next_addr", 32'(mi.mem_addr), 0);
        chk("fr_next_we", 32'(mi.mem_we), 1);
        tick();

        // sof with an accepted byte
        put_byte(8'h77);
        put_byte(8'h88);
        sof = 1'b1;
        put_byte(8'hAA);
        sof = 1'b0;
        chk("sb_wr_x", 32'(wr_x), 0);
        put_byte(8'hBB);
        put_byte(8'hCC);
        #1;
        chk("sb_addr", 32'(mi.mem_addr), 0);
        chk("sb_wdata", 32'(mi.mem_wdata), 32'hCCBBAA);
        tick();
        chk("sb_wr_x_after", 32'(wr_x), 1);

        // sof suppresses a write grant
        send_px(24'h0D0E0F);
        w0 = wcnt;
        sof = 1'b1;
        #1;
        chk("sg_mem_en", 32'(mi.mem_en), 0);
        tick();
        sof = 1'b0;
        #1;
        chk("sg_wr_x", 32'(wr_x), 0);
        chk("sg_ready", 32'(bs.byte_ready), 1);
        chk("sg_no_write", 32'(wcnt - w0), 0);

        // out-of-range reads
        rd_req = 1'b1; rd_x = 10'd100; rd_y = 10'd5;
        #1;
        chk("oor_x_en", 32'(mi.mem_en), 0);
        tick();
        rd_x = 10'd3; rd_y = 10'd100;
        #1;
        chk("oor_x_valid", 32'(rd_valid), 1);
        chk("oor_x_data", 32'(rd_data), 0);
        chk("oor_y_en", 32'(mi.mem_en), 0);
        tick();
        rd_req = 1'b0;
        #1;
        chk("oor_y_valid", 32'(rd_valid), 1);
        chk("oor_y_data", 32'(rd_data), 0);
        tick();
        chk("oor_valid_drop", 32'(rd_valid), 0);

        // async reset mid-frame, in PACK1
        for (int p = 0; p < 700; p++) send_px(24'(p));
        tick();
        put_byte(8'h55);
        chk("mr_wr_y_pre", 32'(wr_y), 7);
        rd_req = 1'b1; rd_x = 10'd0; rd_y = 10'd0;
        tick();
        chk("mr_valid_pre", 32'(rd_valid), 1);
        rd_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mr_rd_valid", 32'(rd_valid), 0);
        chk("mr_rd_data", 32'(rd_data), 0);
        chk("mr_wr_x", 32'(wr_x), 0);
        chk("mr_wr_y", 32'(wr_y), 0);
        chk("mr_frame_done", 32'(frame_done), 0);
        chk("mr_mem_en", 32'(mi.mem_en), 0);
        chk("mr_mem_we", 32'(mi.mem_we), 0);
        chk("mr_mem_addr", 32'(mi.mem_addr), 0);
        chk("mr_mem_wdata", 32'(mi.mem_wdata), 0);
        chk("mr_ready", 32'(bs.byte_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_px(24'h998877);
        #1;
        chk("mr_next_addr", 32'(mi.mem_addr), 0);
        chk("mr_next_wdata", 32'(mi.mem_wdata), 32'h998877);
        tick();
        chk("mr_next_wr_x", 32'(wr_x), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_write_ctrl.md
# frame_write_ctrl

Sequences the incoming byte stream into 24-bit pixel writes on the single-port frame buffer, and shares that port with the display scan-out reader. Packs three bytes per pixel (LSB first) and generates raster write addresses with line/pixel wrap-around. Arbitrates each cycle with fixed priority to scan-out. Sits between the byte source and the frame memory, alongside the display timing block that issues read requests.

## Interface
- H_PIX, 100, pixels per line
- V_LINES, 100, lines per frame
- PIX_W, 24, pixel width (3 × 8-bit bytes)
- AW, $clog2(H_PIX*V_LINES), memory address width
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- sof  in  1  start of frame; restarts packing and the raster at (0,0)
- byte_valid  in  1  byte_in is valid
- byte_in  in  8  pixel byte, order B0=[7:0], B1=[15:8], B2=[23:16]
- byte_ready  out  1  byte accepted when byte_valid && byte_ready
- rd_req  in  1  scan-out read request, one cycle per pixel
- rd_x  in  10  pixel index of the read
- rd_y  in  10  line index of the read
- rd_valid  out  1  rd_data valid
- rd_data  out  24  scan-out pixel
- mem_en, mem_we  out  1  memory enable / write enable
- mem_addr  out  AW  y*H_PIX + x
- mem_wdata  out  24  write pixel
- mem_rdata  in  24  read data, 1-cycle latency after mem_en && !mem_we
- wr_x, wr_y  out  10  raster position of the next pixel write
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written

## Operation
- FSM states: PACK0, PACK1, PACK2, WAIT_WR. Reset state is PACK0.
- PACK0 → PACK1 → PACK2 on each accepted byte; bytes are stored into pix[7:0], pix[15:8], pix[23:16] respectively.
- PACK2 → WAIT_WR on an accepted byte.
- WAIT_WR: byte_ready=0. A write is issued in any cycle where !rd_req, then the FSM returns to PACK0. While rd_req is high the FSM stays in WAIT_WR (writer stalls, no data loss).
- byte_ready = (state != WAIT_WR).
- Arbitration, per cycle:
  - rd_req has priority and drives mem_en=1, mem_we=0, mem_addr=rd_y*H_PIX+rd_x.
  - Otherwise a WAIT_WR write drives mem_en=1, mem_we=1, mem_addr=wr_y*H_PIX+wr_x.
  - Otherwise mem_en=0.
- Raster, after each write:
  - wr_x increments.
  - At wr_x==H_PIX-1: wr_x←0 and wr_y increments.
  - At (H_PIX-1, V_LINES-1): both wrap to 0 and frame_done pulses.
- Out-of-range read (rd_x≥H_PIX or rd_y≥V_LINES): no memory access; rd_valid=1 next cycle with rd_data=0.
- sof: resets the FSM to PACK0 and wr_x/wr_y to 0, and discards any partial or pending pixel.
  - If sof coincides with an accepted byte, that byte becomes B0 of pixel (0,0); the FSM goes to PACK1.
  - If sof coincides with a write grant, the write is suppressed.
- Address multiply: H_PIX is constant; compute at AW bits, no truncation for legal coordinates.

## Timing
- Reset values: state=PACK0, wr_x=wr_y=0, rd_valid=0, rd_data=0, frame_done=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0; byte_ready=1 once in PACK0.
- mem_* outputs are combinational from state, rd_req and counters; memory samples them on the same edge.
- Read latency: rd_req at cycle N → rd_valid/rd_data registered at N+1. rd_valid is high for exactly one cycle per request.
- Write: last byte accepted at N → write at N+1 if no rd_req. Peak throughput is 3 bytes per 4 cycles.
- frame_done is registered: high in the cycle after the final write.
- Reset asserted mid-pixel or mid-frame forces all reset values asynchronously. The partial pixel is lost.

## Structure
- Shared package `display_pkg`: H_PIX, V_LINES, PIX_W, the coordinate width (10), and the FSM state enum `pack_state_t`.
- One sub-module, `pixel_raster_cnt`: wr_x/wr_y counter with clear (sof), advance (write) and wrap/frame_done outputs.
- Arbiter and packer stay in the top.

## Test plan
- Reset, then bytes 0x11, 0x22, 0x33 with no rd_req → one write, addr 0, wdata 0x332211; wr_x=1; byte_ready low for exactly 1 cycle.
- rd_req held for 3 cycles while the FSM is in WAIT_WR → three reads and zero writes; byte_ready=0 throughout; the write occurs in the cycle rd_req drops. rd_data matches the memory model one cycle after each request.
- Stream H_PIX*V_LINES pixels → last write addr 9999; frame_done pulses once; wr_x=wr_y=0 afterwards; the next pixel writes addr 0.
- Send two bytes, then sof together with byte 0xAA → the partial pixel is discarded; the next completed pixel writes addr 0 with [7:0]=0xAA.
- rd_req with rd_x=100, rd_y=5 → mem_en=0; rd_valid=1, rd_data=0 next cycle.
- Assert reset while in PACK1 at wr_y=7 → all outputs take their reset values immediately; after release, the next pixel goes to addr 0.
